// File: rtl/seq_divider_pkg.sv
// Shared definitions for the iterative divider: FSM states, default width
// and the fixed results returned for divide-by-zero and signed overflow.
package seq_divider_pkg;

  localparam int unsigned DIV_WIDTH     = 32;
  localparam int unsigned DIV_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Quotient returned for a zero divisor: all ones at the operand width.
  function automatic logic [DIV_MAX_WIDTH-1:0] div0_quo(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Quotient returned for most-negative / -1: the most-negative value.
  function automatic logic [DIV_MAX_WIDTH-1:0] ovf_quo(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

  // Remainder returned for most-negative / -1.
  localparam logic [DIV_MAX_WIDTH-1:0] OVF_REM = '0;

endpackage

// File: rtl/seq_divider_step.sv
// One restoring division iteration on unsigned magnitudes; purely combinational.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // Partial remainder after the shift needs one extra bit before the compare.
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Shift {rem, quo} left, then subtract the divisor when it fits.
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    diff   = rem_sh - {1'b0, divisor};
    if (rem_sh >= {1'b0, divisor}) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_sh[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider: accepts dividend/divisor when both
// valids are high, returns {quotient, remainder} WIDTH+1 cycles later.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH  = DIV_WIDTH,
  parameter bit          SIGNED = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_axis_dividend_tvalid,
  input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
  input  logic                 s_axis_divisor_tvalid,
  input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
  output logic                 m_axis_dout_tvalid,
  output logic [2*WIDTH-1:0]   m_axis_dout_tdata
);

  localparam int unsigned      CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST   = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] DIV0_Q = WIDTH'(div0_quo(WIDTH));
  localparam logic [WIDTH-1:0] OVF_Q  = WIDTH'(ovf_quo(WIDTH));
  localparam logic [WIDTH-1:0] OVF_R  = WIDTH'(OVF_REM);
  localparam logic [WIDTH-1:0] MIN_S  = WIDTH'(ovf_quo(WIDTH));

  div_state_e state, state_nx;

  logic             accept;
  logic             last_step;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, a_raw_q;
  logic             q_neg_q, r_neg_q, div0_q, ovf_q;

  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             a_neg, b_neg;
  logic             is_div0, is_ovf;
  logic [WIDTH-1:0] q_res, r_res;

  logic [2*WIDTH-1:0] dout_q;
  logic               dout_vld_q;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state, accept strobe and final-iteration strobe.
  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state)
      IDLE: begin
        if (s_axis_dividend_tvalid && s_axis_divisor_tvalid) begin
          accept   = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (cnt == LAST) begin
          last_step = 1'b1;
          state_nx  = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand magnitudes, signs and special-case detection at the accept edge.
  always_comb begin
    a_neg   = SIGNED && s_axis_dividend_tdata[WIDTH-1];
    b_neg   = SIGNED && s_axis_divisor_tdata[WIDTH-1];
    a_mag   = a_neg ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
    b_mag   = b_neg ? -s_axis_divisor_tdata  : s_axis_divisor_tdata;
    is_div0 = (s_axis_divisor_tdata == '0);
    is_ovf  = SIGNED && (s_axis_dividend_tdata == MIN_S) &&
              (s_axis_divisor_tdata == '1);
  end

  // Sign-corrected result of the last iteration, with special cases overriding.
  always_comb begin
    q_res = q_neg_q ? -quo_nx : quo_nx;
    r_res = r_neg_q ? -rem_nx : rem_nx;
    if (div0_q) begin
      q_res = DIV0_Q;
      r_res = a_raw_q;
    end else if (ovf_q) begin
      q_res = OVF_Q;
      r_res = OVF_R;
    end
  end

  // Operand capture, iteration registers, counter and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      a_raw_q    <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div0_q     <= 1'b0;
      ovf_q      <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      dout_vld_q <= 1'b0;
      if (accept) begin
        cnt     <= '0;
        rem_q   <= '0;
        quo_q   <= a_mag;
        dvs_q   <= b_mag;
        a_raw_q <= s_axis_dividend_tdata;
        q_neg_q <= a_neg ^ b_neg;
        r_neg_q <= a_neg;
        div0_q  <= is_div0;
        ovf_q   <= is_ovf;
      end else if (state == BUSY) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt   <= last_step ? '0 : cnt + CW'(1);
        if (last_step) begin
          dout_q     <= {q_res, r_res};
          dout_vld_q <= 1'b1;
        end
      end
    end
  end

  assign m_axis_dout_tvalid = dout_vld_q;
  assign m_axis_dout_tdata  = dout_q;

endmodule
